// File: rtl/arith_pkg.sv
// arith_pkg: shared FSM states and sizing helpers for the sequential arithmetic units
package arith_pkg;
    localparam logic IDLE      = 1'b0;
    localparam logic COMPUTING = 1'b1;
    function automatic int cnt_width(input int n);
        return $clog2(n) + 1;
    endfunction
endpackage

// File: rtl/div_control.sv
// div_control: two-state sequencer issuing load, step and the completion pulse
module div_control
    import arith_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic req,
    input  logic cnt_eq_0,
    output logic load,
    output logic step,
    output logic ack
);
    logic state;
    assign load = state == IDLE && req;
    assign step = state == COMPUTING && !cnt_eq_0;
    assign ack  = state == COMPUTING && cnt_eq_0;
    // Leave IDLE on an accepted request, return once the counter has drained
    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else if (load)
            state <= COMPUTING;
        else if (ack)
            state <= IDLE;
    end
endmodule

// File: rtl/div_datapath.sv
// div_datapath: restoring shift-subtract registers, comparator and step counter
module div_datapath
    import arith_pkg::*;
#(
    parameter int n = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         step,
    input  logic [n-1:0] sbc,
    input  logic [n-1:0] sc,
    output logic [n-1:0] thuong,
    output logic [n-1:0] du,
    output logic         dz,
    output logic         cnt_eq_0
);
    localparam int cw = cnt_width(n);
    logic [n-1:0]  q, r, d;
    logic [cw-1:0] cnt;
    logic [n:0]    t;
    logic          ge;
    // The partial remainder always ends below the divisor, so only the trial
    // value needs the extra top bit for the compare.
    assign t        = {r, q[n-1]};
    assign ge       = t >= {1'b0, d};
    assign thuong   = q;
    assign du       = r;
    assign cnt_eq_0 = cnt == '0;
    // Capture operands on load, then shift in one quotient bit per step
    always_ff @(posedge clk) begin
        if (rst) begin
            q   <= '0;
            r   <= '0;
            d   <= '0;
            cnt <= '0;
            dz  <= 1'b0;
        end else if (load) begin
            q   <= sbc;
            r   <= '0;
            d   <= sc;
            cnt <= cw'(n);
            dz  <= sc == '0;
        end else if (step) begin
            q   <= {q[n-2:0], ge};
            r   <= ge ? t[n-1:0] - d : t[n-1:0];
            cnt <= cnt - cw'(1);
        end
    end
endmodule

// File: rtl/divider.sv
// divider: sequential unsigned restoring divider with req/ack handshake
module divider
    import arith_pkg::*;
#(
    parameter int n = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [n-1:0] sbc,
    input  logic [n-1:0] sc,
    input  logic         req,
    output logic [n-1:0] thuong,
    output logic [n-1:0] du,
    output logic         dz,
    output logic         ack
);
    logic load, step, cnt_eq_0;
    div_control u_ctrl (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .cnt_eq_0 (cnt_eq_0),
        .load     (load),
        .step     (step),
        .ack      (ack)
    );
    div_datapath #(.n(n)) u_dp (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .step     (step),
        .sbc      (sbc),
        .sc       (sc),
        .thuong   (thuong),
        .du       (du),
        .dz       (dz),
        .cnt_eq_0 (cnt_eq_0)
    );
endmodule
